adder_test_sequencer: RTL
=========================

Name: adder_test_sequencer

Overview:
- Self-test controller that drives the 4-bit adder datapath through every operand combination {cin, B, A} (exhaustive sweep).
- After a programmable settle time it samples the adder result and checks it against an internally computed reference.
- Counts mismatches, captures the first failing vector and reports pass/fail to the bench or top level.
- Replaces free-running stimulus counters with a start/abort/done handshake.

Parameters:
- WIDTH, 4, operand width of the adder under control (legal 1..7).
- SETTLE_CYCLES, 2, cycles the operands are held before the result is sampled (legal >=1).

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle or level request; accepted only in IDLE or DONE.
- abort_i  input  1  synchronous abort of a running sweep.
- sum_i  input  WIDTH  adder sum result.
- cout_i  input  1  adder carry-out.
- A  output  WIDTH  operand A to adder.
- B  output  WIDTH  operand B to adder.
- cin  output  1  carry-in to adder.
- busy  output  1  high while a sweep is running (SETTLE/CHECK).
- done  output  1  high in DONE state.
- pass  output  1  done && err_cnt==0.
- err_cnt  output  16  mismatch count, saturates at 16'hFFFF.
- first_fail  output  2*WIDTH+1  {cin,B,A} of first mismatch; valid when err_cnt!=0.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; vec=0; A=B=cin=0.
  - busy=done=pass=0; err_cnt=0; first_fail=0.
- Internal vector register vec[2*WIDTH:0]:
  - A=vec[WIDTH-1:0], B=vec[2*WIDTH-1:WIDTH], cin=vec[2*WIDTH].
  - Outputs are driven directly from registers only.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE, start_i=1 at edge:
  - vec<=0, err_cnt<=0, first_fail<=0, settle counter<=0.
  - state<=SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, state<=CHECK.
  - Operands are therefore stable for SETTLE_CYCLES cycles before CHECK.
- CHECK (one cycle):
  - At the closing edge, compare {cout_i,sum_i} with A+B+cin computed at WIDTH+1 bits.
  - On mismatch: err_cnt increments (saturating); if err_cnt was 0, first_fail<=vec.
  - If vec==all-ones: state<=DONE, vec holds.
  - Otherwise: vec<=vec+1, counter<=0, state<=SETTLE.
- Timing:
  - Per vector: SETTLE_CYCLES+1 cycles.
  - Sweep length: 2^(2*WIDTH+1)*(SETTLE_CYCLES+1) cycles from the accept edge to the DONE entry edge. Default: 512*3=1536.
- DONE:
  - done=1; pass=(err_cnt==0).
  - Results hold until the next accepted start.
- Handshake and priority:
  - start_i while busy is ignored.
  - abort_i has priority over start_i and over the CHECK update in the same cycle.
  - abort_i in SETTLE/CHECK: state<=IDLE, vec<=0 (A=B=cin=0), done=0. err_cnt and first_fail keep values accumulated before that edge.
  - abort_i in IDLE/DONE: no effect.
- Async reset mid-sweep returns immediately to reset values; no resume.
- busy=1 exactly in SETTLE and CHECK.

Test Plan:
- Ideal adder model connected, default params, start pulse:
  - busy rises next edge.
  - done=1 exactly 1536 cycles after the accept edge.
  - err_cnt=0, pass=1.
- sum_i[0] stuck at 0:
  - done after 1536 cycles.
  - err_cnt=256, first_fail=9'h001, pass=0.
- cout_i tied 0:
  - err_cnt=256 (120 with cin=0, 136 with cin=1).
  - first_fail=9'h01F (B=1, A=15).
- SETTLE_CYCLES=1, ideal adder:
  - done after 1024 cycles.
  - A/B/cin step every 2 cycles, in order 0x000,0x001,...,0x1FF.
- abort_i at cycle 100 of a sweep with a faulty adder:
  - Next edge: busy=0, done=0, A=B=cin=0.
  - err_cnt frozen.
  - A new start clears err_cnt and the sweep restarts from vec=0.
- Corner checks:
  - start_i held high through a whole run: ignored while busy, restarts from DONE.
  - rst low mid-sweep: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/adder_test_sequencer.sv
// Exhaustive self-test sequencer for a WIDTH-bit ripple adder: sweeps every {cin,B,A},
// waits SETTLE_CYCLES per vector, checks the sum, and reports mismatch statistics.
module adder_test_sequencer #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [WIDTH-1:0]   sum_i,
   input  logic               cout_i,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   output logic               cin,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [15:0]        err_cnt,
   output logic [2*WIDTH:0]   first_fail
);

   localparam int VEC_W = 2*WIDTH + 1;
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      err_q, err_d;
   logic [VEC_W-1:0] ff_q, ff_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic [WIDTH:0]   ref_sum;
   logic             mismatch;

   // Reference result at WIDTH+1 bits so the carry-out is compared too.
   assign ref_sum  = {1'b0, vec_q[WIDTH-1:0]} + {1'b0, vec_q[2*WIDTH-1:WIDTH]}
                   + {{WIDTH{1'b0}}, vec_q[2*WIDTH]};
   assign mismatch = ({cout_i, sum_i} != ref_sum);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_SETTLE;
               vec_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               ff_d    = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            if (abort_i) begin
               state_d = S_IDLE;
               vec_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            // Abort wins over the result update of this cycle.
            if (abort_i) begin
               state_d = S_IDLE;
               vec_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end else begin
               if (mismatch) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (err_q == 16'd0)    ff_d  = vec_q;
               end
               if (vec_q == {VEC_W{1'b1}}) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 16'd0);
               end else begin
                  state_d = S_SETTLE;
                  vec_d   = vec_q + 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign A          = vec_q[WIDTH-1:0];
   assign B          = vec_q[2*WIDTH-1:WIDTH];
   assign cin        = vec_q[2*WIDTH];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_q;
   assign first_fail = ff_q;

endmodule
